// File: rtl/button_conditioner.sv
// button_conditioner: front end for the board push-buttons.
// Each button is synchronised, debounced, and turned into a clean level
// plus one-cycle press / release / long-press pulses. A small priority
// encoder folds the press pulses into one event (valid + lowest index).
//
// Event interface: press_valid is a one-cycle strobe with no ready/backpressure.
// press_code and multi_press are meaningful only while press_valid=1
// (press_code reads 0 otherwise). The consumer must sample on every cycle.
module button_conditioner #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 100000000,
    parameter int CNT_W           = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long,
    output logic             press_valid,
    output logic [2:0]       press_code,
    output logic             multi_press
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [N_BTN-1:0] BTN_ONE   = N_BTN'(1);

    logic [N_BTN-1:0] sync_a;
    logic [N_BTN-1:0] sync_b;
    logic [CNT_W-1:0] dcnt [N_BTN];
    logic [CNT_W-1:0] lcnt [N_BTN];
    logic [N_BTN-1:0] fired;

    // Two-flop synchroniser; sync_b is the only view of the pads used downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
        end
    end

    // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; press/release pulse in the cycle the level changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BTN; i++) begin
                dcnt[i] <= '0;
            end
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            btn_press   <= '0;
            btn_release <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                if (sync_b[i] == btn_level[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DB_LAST) begin
                    btn_level[i]   <= sync_b[i];
                    btn_press[i]   <= sync_b[i];
                    btn_release[i] <= ~sync_b[i];
                    dcnt[i]        <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Long press: count held cycles once per press; fired blocks repeats
    // until the debounced level drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_BTN; i++) begin
                lcnt[i] <= '0;
            end
            fired    <= '0;
            btn_long <= '0;
        end else begin
            btn_long <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                if (!btn_level[i]) begin
                    lcnt[i]  <= '0;
                    fired[i] <= 1'b0;
                end else if (!fired[i]) begin
                    if (lcnt[i] == LONG_LAST) begin
                        btn_long[i] <= 1'b1;
                        fired[i]    <= 1'b1;
                    end else begin
                        lcnt[i] <= lcnt[i] + CNT_ONE;
                    end
                end
            end
        end
    end

    // Priority encoder over the press pulses: lowest index wins.
    always_comb begin
        press_code = 3'd0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (btn_press[i]) begin
                press_code = 3'(i);
            end
        end
        press_valid = |btn_press;
        // Clearing the lowest set bit leaves something only if two or more were set.
        multi_press = |(btn_press & (btn_press - BTN_ONE));
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/long thresholds.
module tb_button_conditioner;

    localparam int NB = 5;
    localparam int DB = 4;
    localparam int LG = 10;
    localparam int CW = 4;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_long;
    logic          press_valid;
    logic [2:0]    press_code;
    logic          multi_press;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BTN(NB), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG), .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn_raw(btn_raw),
        .btn_level(btn_level),
        .btn_press(btn_press),
        .btn_release(btn_release),
        .btn_long(btn_long),
        .press_valid(press_valid),
        .press_code(press_code),
        .multi_press(multi_press)
    );

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- scoreboard / pulse monitor ----------------
    logic [2:0] exp_q[$];
    logic [2:0] exp_code;
    int press_cnt [NB] = '{default: 0};
    int rel_cnt   [NB] = '{default: 0};
    int long_cnt  [NB] = '{default: 0};

    always @(negedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (btn_press[i])   press_cnt[i]++;
            if (btn_release[i]) rel_cnt[i]++;
            if (btn_long[i])    long_cnt[i]++;
        end
        if (press_valid) begin
            if (exp_q.size() != 0) begin
                exp_code = exp_q.pop_front();
                check("ev_code", 32'(press_code), 32'(exp_code));
            end else begin
                check("ev_spurious", 32'(press_code), 32'hff);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"}, 32'(btn_level), 0);
        check({tag, "_press"}, 32'(btn_press), 0);
        check({tag, "_rel"},   32'(btn_release), 0);
        check({tag, "_long"},  32'(btn_long), 0);
        check({tag, "_valid"}, 32'(press_valid), 0);
        check({tag, "_code"},  32'(press_code), 0);
        check({tag, "_multi"}, 32'(multi_press), 0);
    endtask

    // ---------------- stimulus ----------------
    int p0, r0, l0;

    initial begin
        rst_n   = 1'b0;
        btn_raw = '0;
        step(2);
        check_all_zero("rst");
        rst_n = 1'b1;
        step(3);

        // Clean press on Center
        exp_q.push_back(3'd0);
        btn_raw = 5'b00001;
        step(5);
        check("clean_lvl_early", 32'(btn_level), 0);
        step(1);
        check("clean_lvl", 32'(btn_level), 32'b00001);
        check("clean_press", 32'(btn_press), 32'b00001);
        check("clean_valid", 32'(press_valid), 1);
        check("clean_code", 32'(press_code), 0);
        check("clean_multi", 32'(multi_press), 0);
        step(1);
        check("clean_press_1cyc", 32'(btn_press), 0);
        check("clean_valid_1cyc", 32'(press_valid), 0);
        btn_raw = '0;
        step(6);
        check("clean_rel", 32'(btn_release), 32'b00001);
        check("clean_lvl_fall", 32'(btn_level), 0);
        step(2);
        check("clean_no_long", 32'(long_cnt[0]), 0);

        // Bounce on Bottom
        p0 = press_cnt[2];
        exp_q.push_back(3'd2);
        btn_raw[2] = 1'b1; step(1);
        btn_raw[2] = 1'b0; step(2);
        btn_raw[2] = 1'b1; step(3);
        btn_raw[2] = 1'b0; step(2);
        btn_raw[2] = 1'b1;
        step(5);
        check("bounce_lvl_early", 32'(btn_level), 0);
        check("bounce_no_press", 32'(press_cnt[2] - p0), 0);
        step(1);
        check("bounce_press", 32'(btn_press), 32'b00100);
        check("bounce_code", 32'(press_code), 2);
        btn_raw[2] = 1'b0;
        step(8);
        check("bounce_one_press", 32'(press_cnt[2] - p0), 1);

        // Long press on Right
        p0 = press_cnt[4]; r0 = rel_cnt[4]; l0 = long_cnt[4];
        exp_q.push_back(3'd4);
        btn_raw[4] = 1'b1;
        step(6);
        check("long_press", 32'(btn_press), 32'b10000);
        step(9);
        check("long_early", 32'(btn_long), 0);
        step(1);
        check("long_fire", 32'(btn_long), 32'b10000);
        step(10);
        check("long_after", 32'(btn_long), 0);
        btn_raw[4] = 1'b0;
        step(5);
        check("long_rel_early", 32'(btn_release), 0);
        check("long_lvl_held", 32'(btn_level), 32'b10000);
        step(1);
        check("long_rel", 32'(btn_release), 32'b10000);
        step(2);
        check("long_cnt", 32'(long_cnt[4] - l0), 1);
        check("long_rel_cnt", 32'(rel_cnt[4] - r0), 1);
        check("long_press_cnt", 32'(press_cnt[4] - p0), 1);

        // Short press on Top
        p0 = press_cnt[1]; r0 = rel_cnt[1]; l0 = long_cnt[1];
        exp_q.push_back(3'd1);
        btn_raw[1] = 1'b1;
        step(8);
        btn_raw[1] = 1'b0;
        step(20);
        check("short_press_cnt", 32'(press_cnt[1] - p0), 1);
        check("short_rel_cnt", 32'(rel_cnt[1] - r0), 1);
        check("short_no_long", 32'(long_cnt[1] - l0), 0);

        // Simultaneous Top + Left
        exp_q.push_back(3'd1);
        btn_raw = 5'b01010;
        step(6);
        check("simul_press", 32'(btn_press), 32'b01010);
        check("simul_code", 32'(press_code), 1);
        check("simul_multi", 32'(multi_press), 1);
        step(1);
        check("simul_multi_1cyc", 32'(multi_press), 0);
        btn_raw = '0;
        step(8);

        // Reset mid-debounce (Center) and mid-long-press (Left)
        exp_q.push_back(3'd3);
        btn_raw[3] = 1'b1;
        step(6);
        check("rst_pre_lvl", 32'(btn_level), 32'b01000);
        r0 = rel_cnt[0] + rel_cnt[3];
        l0 = long_cnt[3];
        btn_raw[0] = 1'b1;
        step(5);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        step(2);
        rst_n = 1'b1;
        exp_q.push_back(3'd0);
        step(5);
        check("rst_lvl_early", 32'(btn_level), 0);
        step(1);
        check("rst_lvl", 32'(btn_level), 32'b01001);
        check("rst_press", 32'(btn_press), 32'b01001);
        check("rst_code", 32'(press_code), 0);
        check("rst_multi", 32'(multi_press), 1);
        step(2);
        check("rst_no_rel", 32'(rel_cnt[0] + rel_cnt[3] - r0), 0);
        check("rst_no_long", 32'(long_cnt[3] - l0), 0);

        step(2);
        check("ev_left", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
